// File: rtl/cpu_mc_pkg.sv
// rtl/cpu_mc_pkg.sv - opcode and FSM state definitions shared by the cpu_mc files
package cpu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_LI   = 4'd7;
  localparam logic [3:0] OP_BEQZ = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;
  localparam logic [3:0] OP_JAL  = 4'd10;
  localparam logic [3:0] OP_JR   = 4'd11;
  localparam logic [3:0] OP_LD   = 4'd12;
  localparam logic [3:0] OP_ST   = 4'd13;
  localparam logic [3:0] OP_NOP  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_MEM    = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_mc_if.sv
// rtl/cpu_mc_if.sv - instruction and data memory req/ack bus
// master: core side (drives req/addr/wdata/we), slave: memory side (drives ack/data)
interface cpu_mc_if #(
  parameter int W  = 10,
  parameter int AW = 10
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [W-1:0]  imem_data;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [W-1:0]  dmem_wdata;
  logic          dmem_ack;
  logic [W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_data, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_data, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu_mc_regfile.sv
// rtl/cpu_mc_regfile.sv - register file, 2 async read ports, 1 sync write port
// ports: clk, reset (async active-low clear), ra1_i/rd1_o, ra2_i/rd2_o, we_i/wa_i/wd_i
module cpu_mc_regfile #(
  parameter int W    = 10,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(NREG)-1:0] ra1_i,
  input  logic [$clog2(NREG)-1:0] ra2_i,
  output logic [W-1:0]            rd1_o,
  output logic [W-1:0]            rd2_o,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] wa_i,
  input  logic [W-1:0]            wd_i
);
  logic [W-1:0] regs_q [NREG];

  // entry 0 is never written, so r0 reads as zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];
endmodule

// File: rtl/cpu_mc.sv
// rtl/cpu_mc.sv - multi-cycle CPU core with req/ack instruction and data memories
// ports: clk, reset (async active-low), bus (cpu_mc_if master), donebit, pc_out
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int W    = 10,
  parameter int NREG = 8,
  parameter int AW   = 10
) (
  input  logic          clk,
  input  logic          reset,
  cpu_mc_if.master      bus,
  output logic          donebit,
  output logic [AW-1:0] pc_out
);
  localparam int R  = $clog2(NREG);
  localparam int SW = W - 4 - R;
  localparam logic [R-1:0] LINK = R'(NREG - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [W-1:0]  instr_q, instr_d;
  logic          done_q, done_d;
  // low during reset and the first cycle after it, so no request is seen while reset is asserted
  logic          run_q;

  logic [3:0]          op;
  logic [R-1:0]        rd_a, rs_a;
  logic signed [W-1:0] imm_s, imm_l;
  logic [W-1:0]        rd_val, rs_val, alu_res;
  logic [AW-1:0]       pc_inc, pc_br, pc_j;
  logic                rf_we;
  logic [R-1:0]        rf_wa;
  logic [W-1:0]        rf_wd;

  assign op    = instr_q[W-1 -: 4];
  assign rd_a  = instr_q[W-5 -: R];
  assign rs_a  = instr_q[W-5-R -: R];
  assign imm_s = {{(4+R){instr_q[SW-1]}}, instr_q[SW-1:0]};
  assign imm_l = {{4{instr_q[W-5]}}, instr_q[W-5:0]};

  assign pc_inc = pc_q + AW'(1);
  assign pc_br  = pc_q + AW'(imm_s);
  assign pc_j   = pc_q + AW'(imm_l);

  cpu_mc_regfile #(.W(W), .NREG(NREG)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1_i (rd_a),
    .ra2_i (rs_a),
    .rd1_o (rd_val),
    .rd2_o (rs_val),
    .we_i  (rf_we),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_AND:  alu_res = rd_val & rs_val;
      OP_OR:   alu_res = rd_val | rs_val;
      OP_XOR:  alu_res = rd_val ^ rs_val;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(rd_val) < $signed(rs_val))};
      OP_MOV:  alu_res = rs_val;
      OP_LI:   alu_res = $unsigned(imm_s);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      done_q  <= done_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (run_q && bus.imem_ack) state_d = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_LD || op == OP_ST) state_d = ST_MEM;
        else if (op == OP_HALT)         state_d = ST_HALTED;
        else                            state_d = ST_FETCH;
      end
      ST_MEM:  if (bus.dmem_ack) state_d = ST_FETCH;
      default: state_d = ST_HALTED;
    endcase
  end

  // datapath: instruction latch, PC update and register write-back
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    done_d  = done_q;
    rf_we   = 1'b0;
    rf_wa   = rd_a;
    rf_wd   = alu_res;
    case (state_q)
      ST_FETCH: if (run_q && bus.imem_ack) instr_d = bus.imem_data;
      ST_EXEC: begin
        case (op)
          OP_BEQZ: pc_d = (rd_val == '0) ? pc_br : pc_inc;
          OP_J:    pc_d = pc_j;
          OP_JAL: begin
            pc_d  = pc_j;
            rf_we = 1'b1;
            rf_wa = LINK;
            rf_wd = W'(pc_inc);
          end
          OP_JR:   pc_d = AW'(rd_val);
          OP_LD, OP_ST: pc_d = pc_q;
          OP_NOP:  pc_d = pc_inc;
          OP_HALT: done_d = 1'b1;
          default: begin
            rf_we = 1'b1;
            pc_d  = pc_inc;
          end
        endcase
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          pc_d = pc_inc;
          if (op == OP_LD) begin
            rf_we = 1'b1;
            rf_wd = bus.dmem_rdata;
          end
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  always_comb begin
    bus.imem_req   = run_q && (state_q == ST_FETCH);
    bus.imem_addr  = pc_q;
    bus.dmem_req   = (state_q == ST_MEM);
    bus.dmem_we    = (state_q == ST_MEM) && (op == OP_ST);
    bus.dmem_addr  = AW'(rs_val);
    bus.dmem_wdata = rd_val;
    donebit        = done_q;
    pc_out         = pc_q;
  end
endmodule

// File: tb/tb_cpu_mc.sv
// tb/tb_cpu_mc.sv - directed self-checking bench for cpu_mc
module tb_cpu_mc;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       donebit;
  logic [9:0] pc_out;

  cpu_mc_if #(.W(10), .AW(10)) bus ();

  cpu_mc #(.W(10), .NREG(8), .AW(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .donebit (donebit),
    .pc_out  (pc_out)
  );

  always #5 clk = ~clk;

  logic [9:0] imem [1024];
  logic [9:0] dmem [1024];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mem_auto;
  int         iwait, dwait, icnt, dcnt, st_count, edges;
  logic [9:0] st_addr, st_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] reg_val(input int i);
    return dut.u_rf.regs_q[i];
  endfunction

  // memory model drives acks before each edge, then samples 1 time unit after it
  task automatic step();
    if (mem_auto) begin
      if (bus.imem_req) begin
        if (icnt >= iwait) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = imem[bus.imem_addr];
          icnt = 0;
        end else begin
          bus.imem_ack = 1'b0;
          icnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        icnt = 0;
      end
      if (bus.dmem_req) begin
        if (dcnt >= dwait) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = dmem[bus.dmem_addr];
          if (bus.dmem_we) begin
            dmem[bus.dmem_addr] = bus.dmem_wdata;
            st_count++;
            st_addr = bus.dmem_addr;
            st_data = bus.dmem_wdata;
          end
          dcnt = 0;
        end else begin
          bus.dmem_ack = 1'b0;
          dcnt++;
        end
      end else begin
        bus.dmem_ack = 1'b0;
        dcnt = 0;
      end
    end
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic fill(input logic [9:0] v);
    for (int i = 0; i < 1024; i++) begin
      imem[i] = v;
      dmem[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.imem_data = '0;
    bus.dmem_rdata = '0;
    icnt = 0;
    dcnt = 0;
    st_count = 0;
    st_addr = '0;
    st_data = '0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    edges = 0;
  endtask

  task automatic run_to(input int n);
    while (edges < n) step();
  endtask

  task automatic run_halt(input int budget);
    int c = 0;
    while (!donebit && c < budget) begin
      step();
      c++;
    end
    check("halt_reached", donebit, 1);
  endtask

  initial begin
    int c_req;
    mem_auto = 1'b0;
    iwait = 0;
    dwait = 0;
    edges = 0;
    fill(10'h3C0);

    // reset state and a held-off fetch
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.imem_data = '0;
    bus.dmem_rdata = '0;
    @(posedge clk);
    #1;
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    check("rst_dmem_we", bus.dmem_we, 0);
    check("rst_done", donebit, 0);
    check("rst_pc", pc_out, 0);
    #2 reset = 1'b1;
    step();
    check("first_imem_req", bus.imem_req, 1);
    check("first_imem_addr", bus.imem_addr, 0);
    repeat (3) step();
    check("stall_imem_req", bus.imem_req, 1);
    check("stall_imem_addr", bus.imem_addr, 0);
    check("stall_pc", pc_out, 0);

    // ALU program ending in a store and HALT
    fill(10'h3C0);
    imem[0] = 10'h1CB; imem[1] = 10'h1D2; imem[2] = 10'h00A;
    imem[3] = 10'h34A; imem[4] = 10'h3C0;
    mem_auto = 1'b1;
    do_reset();
    run_to(11);
    check("alu_done_early", donebit, 0);
    run_to(12);
    check("alu_done_c12", donebit, 1);
    check("alu_st_count", st_count, 1);
    check("alu_st_addr", st_addr, 2);
    check("alu_st_data", st_data, 5);
    c_req = 0;
    repeat (5) begin
      step();
      if (bus.imem_req) c_req++;
    end
    check("halt_no_fetch", c_req, 0);
    check("halt_done_sticky", donebit, 1);
    check("halt_pc_frozen", pc_out, 4);

    // BEQZ taken and not taken
    fill(10'h3C0);
    imem[0] = 10'h1D8; imem[1] = 10'h21F;
    do_reset();
    run_to(5);
    check("beqz_taken_req", bus.imem_req, 1);
    check("beqz_taken_addr", bus.imem_addr, 0);
    imem[0] = 10'h1D9;
    do_reset();
    run_to(5);
    check("beqz_not_taken_addr", bus.imem_addr, 2);

    // JAL / JR
    fill(10'h380);
    imem[5] = 10'h284; imem[9] = 10'h2F8; imem[6] = 10'h3C0;
    do_reset();
    run_to(11);
    check("jal_fetch_addr", bus.imem_addr, 5);
    run_to(13);
    check("jal_target", bus.imem_addr, 9);
    check("jal_link_r7", reg_val(7), 6);
    run_to(15);
    check("jr_target", bus.imem_addr, 6);
    run_halt(20);
    check("jr_halt_pc", pc_out, 6);

    // LD with two wait states, SLT against r0, store result
    fill(10'h3C0);
    imem[0] = 10'h320; imem[1] = 10'h160; imem[2] = 10'h360;
    dmem[0] = 10'h3FF;
    dwait = 2;
    do_reset();
    run_to(5);
    check("ld_wait_req", bus.dmem_req, 1);
    check("ld_wait_we", bus.dmem_we, 0);
    check("ld_wait_pc", pc_out, 0);
    run_to(6);
    check("ld_done_pc", pc_out, 1);
    check("ld_r4", reg_val(4), 10'h3FF);
    run_to(8);
    check("slt_r4", reg_val(4), 1);
    run_halt(40);
    check("slt_st_data", st_data, 1);
    check("slt_st_addr", st_addr, 0);

    // reset in the middle of a data transfer
    fill(10'h3C0);
    imem[0] = 10'h1CB; imem[1] = 10'h311;
    dwait = 5;
    do_reset();
    run_to(6);
    check("mid_dmem_req", bus.dmem_req, 1);
    check("mid_dmem_addr", bus.dmem_addr, 3);
    check("mid_r1", reg_val(1), 3);
    reset = 1'b0;
    #1;
    check("abort_dmem_req", bus.dmem_req, 0);
    check("abort_imem_req", bus.imem_req, 0);
    check("abort_pc", pc_out, 0);
    #2 reset = 1'b1;
    edges = 0;
    dwait = 0;
    for (int i = 0; i < 8; i++) check($sformatf("abort_r%0d", i), reg_val(i), 0);
    step();
    check("restart_req", bus.imem_req, 1);
    check("restart_addr", bus.imem_addr, 0);

    // PC wrap at 2^AW-1
    fill(10'h380);
    imem[0] = 10'h27F;
    do_reset();
    run_to(3);
    check("wrap_top_addr", bus.imem_addr, 10'h3FF);
    run_to(5);
    check("wrap_zero_addr", bus.imem_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
